// File: rtl/vector_alu_seq_pkg.sv
// Shared definitions for the sequential vector ALU: opcodes, FP16 field layout,
// FSM/lane-op encodings and the single-cycle scalar-op result function.
package vector_alu_seq_pkg;

    localparam logic [3:0] OP_VADD = 4'b0000;
    localparam logic [3:0] OP_VDOT = 4'b0001;
    localparam logic [3:0] OP_SMUL = 4'b0010;
    localparam logic [3:0] OP_SST  = 4'b0011;
    localparam logic [3:0] OP_VLD  = 4'b0100;
    localparam logic [3:0] OP_VST  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SLH  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    localparam int FP_EW    = 16;
    localparam int FP_EXP_W = 5;
    localparam int FP_MAN_W = 10;
    localparam int FP_BIAS  = 15;
    localparam logic [FP_EW-1:0] FP_QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        LOP_ADD,
        LOP_MUL,
        LOP_MAC
    } lane_op_t;

    function automatic logic is_vector_op(input logic [3:0] opc);
        return (opc == OP_VADD) || (opc == OP_VDOT) || (opc == OP_SMUL);
    endfunction

    // Byte-merge and address-adder ops; anything else (NOP, undefined) yields zero.
    function automatic logic [15:0] scalar_result(input logic [3:0] opc,
                                                  input logic [15:0] a,
                                                  input logic [15:0] b);
        logic [15:0] y;
        case (opc)
            OP_SLL:                      y = {a[15:8], b[7:0]};
            OP_SLH:                      y = {b[7:0], a[7:0]};
            OP_SST, OP_VLD, OP_VST, OP_J: y = a + b;
            default:                     y = '0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/vector_alu_seq_if.sv
// Issue/writeback handshake bundle between decode, the vector ALU and writeback.
interface vector_alu_seq_if #(
    parameter int VW = 256
) ();
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    opcode;
    logic [VW-1:0] op_1;
    logic [VW-1:0] op_2;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] result;

    modport master (
        output in_valid, opcode, op_1, op_2, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, opcode, op_1, op_2, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/vector_alu_seq_fp16_lane.sv
// One FP16 element unit: add, multiply, or chained multiply-accumulate (c + a*b).
// Round toward zero, denormals flushed to signed zero, overflow to signed Inf.
module vector_alu_seq_fp16_lane
    import vector_alu_seq_pkg::*;
(
    input  lane_op_t         i_op,
    input  logic [FP_EW-1:0] i_a,
    input  logic [FP_EW-1:0] i_b,
    input  logic [FP_EW-1:0] i_c,
    output logic [FP_EW-1:0] o_y
);
    localparam logic [FP_EXP_W-1:0] EXP_MAX = '1;

    function automatic logic [FP_EW-1:0] fp_mul(input logic [FP_EW-1:0] a, input logic [FP_EW-1:0] b);
        logic                s;
        logic [FP_EXP_W-1:0] ea, eb;
        logic [FP_MAN_W-1:0] ma, mb;
        logic [21:0]         p;
        logic [6:0]          e_sum;
        logic [FP_EW-1:0]    y;
        s     = a[15] ^ b[15];
        ea    = a[14:10];
        eb    = b[14:10];
        ma    = a[9:0];
        mb    = b[9:0];
        p     = 22'({1'b1, ma}) * 22'({1'b1, mb});
        e_sum = 7'(ea) + 7'(eb) + 7'(p[21]);
        if ((ea == EXP_MAX && ma != '0) || (eb == EXP_MAX && mb != '0))
            y = FP_QNAN;
        else if (ea == EXP_MAX || eb == EXP_MAX)
            y = (ea == '0 || eb == '0) ? FP_QNAN : {s, EXP_MAX, 10'h0};
        else if (ea == '0 || eb == '0 || e_sum <= 7'(FP_BIAS))
            y = {s, 15'h0};
        else if (e_sum >= 7'(FP_BIAS + 31))
            y = {s, EXP_MAX, 10'h0};
        else
            y = {s, 5'(e_sum - 7'(FP_BIAS)), (p[21] ? p[20:11] : p[19:10])};
        return y;
    endfunction

    // The smaller operand keeps 14 guard bits plus a sticky; subtracting the sticky
    // makes plain truncation of the difference exact round-toward-zero.
    function automatic logic [FP_EW-1:0] fp_add(input logic [FP_EW-1:0] a, input logic [FP_EW-1:0] b);
        logic                sa, sb, s_big, s_sml;
        logic [FP_EXP_W-1:0] ea, eb, e_big, e_sml;
        logic [FP_MAN_W-1:0] ma, mb, m_big, m_sml;
        logic [49:0]         sh;
        logic [24:0]         f_big;
        logic                sticky;
        logic [25:0]         sum, norm;
        logic [4:0]          lead;
        logic [6:0]          e_tmp;
        logic [FP_EW-1:0]    y;
        sa = a[15]; ea = a[14:10]; ma = a[9:0];
        sb = b[15]; eb = b[14:10]; mb = b[9:0];
        if ({ea, ma} >= {eb, mb}) begin
            s_big = sa; e_big = ea; m_big = ma;
            s_sml = sb; e_sml = eb; m_sml = mb;
        end else begin
            s_big = sb; e_big = eb; m_big = mb;
            s_sml = sa; e_sml = ea; m_sml = ma;
        end
        f_big  = {1'b1, m_big, 14'h0};
        sh     = {1'b1, m_sml, 14'h0, 25'h0} >> (e_big - e_sml);
        sticky = |sh[24:0];
        if (s_big == s_sml)
            sum = {1'b0, f_big} + {1'b0, sh[49:25]};
        else
            sum = {1'b0, f_big} - {1'b0, sh[49:25]} - 26'(sticky);
        lead = '0;
        for (int i = 0; i < 26; i++)
            if (sum[i]) lead = 5'(i);
        e_tmp = 7'(e_big) + 7'(lead);
        norm  = sum << (5'd25 - lead);
        if ((ea == EXP_MAX && ma != '0) || (eb == EXP_MAX && mb != '0))
            y = FP_QNAN;
        else if (ea == EXP_MAX && eb == EXP_MAX)
            y = (sa != sb) ? FP_QNAN : a;
        else if (ea == EXP_MAX)
            y = a;
        else if (eb == EXP_MAX)
            y = b;
        else if (ea == '0 && eb == '0)
            y = {sa & sb, 15'h0};
        else if (ea == '0)
            y = b;
        else if (eb == '0)
            y = a;
        else if (sum == '0)
            y = '0;
        else if (e_tmp <= 7'd24)
            y = {s_big, 15'h0};
        else if (e_tmp >= 7'd55)
            y = {s_big, EXP_MAX, 10'h0};
        else
            y = {s_big, 5'(e_tmp - 7'd24), norm[24:15]};
        return y;
    endfunction

    logic [FP_EW-1:0] w_prod;

    always_comb begin
        w_prod = fp_mul(i_a, i_b);
        o_y    = '0;
        case (i_op)
            LOP_ADD: o_y = fp_add(i_a, i_b);
            LOP_MUL: o_y = w_prod;
            LOP_MAC: o_y = fp_add(i_c, w_prod);
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/vector_alu_seq.sv
// Multi-cycle vector ALU: LPC FP16 lanes per cycle for VADD/SMUL, one MAC per cycle
// for VDOT, single-cycle scalar ops. The accept cycle already performs the first pass.
module vector_alu_seq
    import vector_alu_seq_pkg::*;
#(
    parameter int LANES = 16,
    parameter int EW    = 16,
    parameter int LPC   = 4
) (
    input  logic           clk,
    input  logic           rst,
    vector_alu_seq_if.slave bus
);
    localparam int VW = LANES * EW;
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

    if (LANES % LPC != 0) begin : g_chk_lpc
        $error("vector_alu_seq: LANES (%0d) must be a multiple of LPC (%0d)", LANES, LPC);
    end
    if (EW != FP_EW) begin : g_chk_ew
        $error("vector_alu_seq: only EW=16 (FP16) lanes are implemented, got %0d", EW);
    end

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_opcode;
    logic [VW-1:0] r_op_1, r_op_2, r_result;
    logic [CW-1:0] r_cnt;
    logic [EW-1:0] r_acc;

    // In IDLE the datapath looks straight at the bus so the accept edge does pass 0.
    logic          w_idle, w_accept, w_lane_en, w_last;
    logic          w_is_vdot, w_is_smul, w_is_vec;
    logic [3:0]    w_opc;
    logic [VW-1:0] w_src1, w_src2;
    logic [CW-1:0] w_cnt;
    logic [EW-1:0] w_acc;
    lane_op_t      w_lane_op;
    logic [CW-1:0] w_idx    [LPC];
    logic [EW-1:0] w_lane_a [LPC];
    logic [EW-1:0] w_lane_b [LPC];
    logic [EW-1:0] w_lane_y [LPC];

    assign w_idle    = (r_state == ST_IDLE);
    assign w_accept  = w_idle && bus.in_valid;
    assign w_opc     = w_idle ? bus.opcode : r_opcode;
    assign w_src1    = w_idle ? bus.op_1 : r_op_1;
    assign w_src2    = w_idle ? bus.op_2 : r_op_2;
    assign w_cnt     = w_idle ? '0 : r_cnt;
    assign w_acc     = w_idle ? '0 : r_acc;
    assign w_is_vdot = (w_opc == OP_VDOT);
    assign w_is_smul = (w_opc == OP_SMUL);
    assign w_is_vec  = is_vector_op(w_opc);
    assign w_last    = w_is_vdot ? (w_cnt == CW'(LANES - 1)) : (w_cnt == CW'(LANES - LPC));
    assign w_lane_en = (w_accept && w_is_vec) || (r_state == ST_RUN);
    assign w_lane_op = w_is_vdot ? LOP_MAC : (w_is_smul ? LOP_MUL : LOP_ADD);

    for (genvar j = 0; j < LPC; j++) begin : g_lane
        assign w_idx[j]    = w_cnt + CW'(j);
        assign w_lane_a[j] = w_is_smul ? w_src1[EW-1:0] : w_src1[w_idx[j]*EW +: EW];
        assign w_lane_b[j] = w_src2[w_idx[j]*EW +: EW];

        vector_alu_seq_fp16_lane u_lane (
            .i_op (w_lane_op),
            .i_a  (w_lane_a[j]),
            .i_b  (w_lane_b[j]),
            .i_c  (w_acc),
            .o_y  (w_lane_y[j])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_opcode <= '0;
            r_op_1   <= '0;
            r_op_2   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_opcode <= bus.opcode;
                r_op_1   <= bus.op_1;
                r_op_2   <= bus.op_2;
            end
            if (w_accept && !w_is_vec)
                r_result <= VW'(scalar_result(bus.opcode, bus.op_1[15:0], bus.op_2[15:0]));
            if (w_lane_en) begin
                if (w_is_vdot) begin
                    r_acc <= w_lane_y[0];
                    if (w_last)
                        r_result <= VW'(w_lane_y[0]);
                    r_cnt <= w_last ? '0 : w_cnt + CW'(1);
                end else begin
                    for (int j = 0; j < LPC; j++)
                        r_result[w_idx[j]*EW +: EW] <= w_lane_y[j];
                    r_cnt <= w_last ? '0 : w_cnt + CW'(LPC);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = (w_is_vec && !w_last) ? ST_RUN : ST_DONE;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = w_idle;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.result    = r_result;

endmodule

// File: tb/tb_vector_alu_seq.sv
// Bench for vector_alu_seq: table of ops with expected results/latency fed through a
// scoreboard queue, plus back-pressure and mid-operation reset sequences.
module tb_vector_alu_seq;
    import vector_alu_seq_pkg::*;

    localparam int LANES = 16;
    localparam int EW    = 16;
    localparam int LPC   = 4;
    localparam int VW    = LANES * EW;
    localparam int NV    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vector_alu_seq_if #(.VW(VW)) bus ();

    vector_alu_seq #(.LANES(LANES), .EW(EW), .LPC(LPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]    opc;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic [VW-1:0] res;
        int            lat;
    } vec_t;

    typedef struct {
        logic [VW-1:0] res;
        int            lat;
    } exp_t;

    vec_t tv [NV];
    exp_t sb_q [$];
    int   checks = 0;
    int   errors = 0;

    logic [15:0] add_a [16] = '{16'h7C00, 16'h7E01, 16'h3C00, 16'h7BFF, 16'h0001, 16'h3C00, 16'h4000, 16'h3C00,
                                16'h3C00, 16'h3C00, 16'hFBFF, 16'hC000, 16'h8000, 16'h3C00, 16'h0400, 16'h0600};
    logic [15:0] add_b [16] = '{16'hFC00, 16'h3C00, 16'hBC00, 16'h7BFF, 16'h0000, 16'h0001, 16'hBC00, 16'h1400,
                                16'h0C00, 16'h8C00, 16'hFBFF, 16'h4000, 16'h8000, 16'h7C00, 16'h8001, 16'h8400};
    logic [15:0] add_y [16] = '{16'h7E00, 16'h7E00, 16'h0000, 16'h7C00, 16'h0000, 16'h3C00, 16'h3C00, 16'h3C01,
                                16'h3C00, 16'h3BFF, 16'hFC00, 16'h0000, 16'h8000, 16'h7C00, 16'h0400, 16'h0000};
    logic [15:0] mul_b [16] = '{16'h3E00, 16'h0000, 16'h8000, 16'h7C00, 16'h7E00, 16'hFC00, 16'h0001, 16'h7BFF,
                                16'hBC00, 16'h3555, 16'h0400, 16'h4000, 16'h0200, 16'h7C01, 16'hC400, 16'h3C00};
    logic [15:0] mul_y [16] = '{16'h4080, 16'h0000, 16'h8000, 16'h7C00, 16'h7E00, 16'hFC00, 16'h0000, 16'h7C00,
                                16'hBE00, 16'h37FF, 16'h0600, 16'h4200, 16'h0000, 16'h7E00, 16'hC600, 16'h3E00};

    function automatic logic [VW-1:0] rep(input logic [15:0] x);
        return {LANES{x}};
    endfunction

    task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic run_op(input vec_t v, input string name, input bit hold);
        int            n;
        exp_t          e;
        logic [VW-1:0] held;
        @(negedge clk);
        check_int({name, " in_ready before issue"}, int'(bus.in_ready), 1);
        bus.in_valid  = 1'b1;
        bus.opcode    = v.opc;
        bus.op_1      = v.a;
        bus.op_2      = v.b;
        bus.out_ready = !hold;
        sb_q.push_back('{v.res, v.lat});
        @(posedge clk);
        n = 1;
        @(negedge clk);
        // Scramble the bus after accept: the unit must work from latched operands.
        bus.in_valid = 1'b0;
        bus.opcode   = OP_VADD;
        bus.op_1     = ~v.a;
        bus.op_2     = ~v.b;
        while (!bus.out_valid && n < 64) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        e = sb_q.pop_front();
        if (!bus.out_valid) begin
            check_int({name, " out_valid timeout"}, 0, 1);
            return;
        end
        check_vec({name, " result"}, bus.result, e.res);
        check_int({name, " latency"}, n, e.lat);
        if (hold) begin
            held = e.res;
            bus.in_valid = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(posedge clk);
                @(negedge clk);
                check_vec({name, " held result"}, bus.result, held);
                check_int({name, " held out_valid"}, int'(bus.out_valid), 1);
                check_int({name, " held in_ready"}, int'(bus.in_ready), 0);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_int({name, " release out_valid"}, int'(bus.out_valid), 0);
            check_int({name, " release in_ready"}, int'(bus.in_ready), 1);
        end
    endtask

    initial begin
        tv[0]  = '{OP_VADD, rep(16'h3C00), rep(16'h3C00), rep(16'h4000), 4};
        tv[1]  = '{OP_VDOT, rep(16'h3C00), rep(16'h3C00), VW'(16'h4C00), 16};
        tv[2]  = '{OP_SMUL, rep(16'h1234), rep(16'h4200), rep(16'h4600), 4};
        tv[2].a[15:0]   = 16'h4000;
        tv[2].b[95:80]  = 16'h7C00;
        tv[2].res[95:80] = 16'h7C00;
        tv[3]  = '{OP_SLL, rep(16'hABCD), rep(16'h0012), VW'(16'hAB12), 1};
        tv[4]  = '{OP_SLH, rep(16'hABCD), rep(16'h0012), VW'(16'h12CD), 1};
        tv[5]  = '{OP_SST, rep(16'hFFF0), rep(16'h0020), VW'(16'h0010), 1};
        tv[6]  = '{OP_VLD, rep(16'h1234), rep(16'h4321), VW'(16'h5555), 1};
        tv[7]  = '{OP_VST, rep(16'h8000), rep(16'h8000), VW'(16'h0000), 1};
        tv[8]  = '{OP_J,   rep(16'h00FF), rep(16'h0001), VW'(16'h0100), 1};
        tv[9]  = '{OP_NOP, rep(16'h1111), rep(16'h2222), '0, 1};
        tv[10] = '{4'b1010, rep(16'h3C00), rep(16'h3C00), '0, 1};
        tv[11] = '{OP_VADD, '0, '0, '0, 4};
        tv[12] = '{OP_SMUL, rep(16'hFFFF), '0, '0, 4};
        tv[12].a[15:0] = 16'h3E00;
        tv[13] = '{OP_SMUL, rep(16'h3C00), rep(16'h4000), '0, 4};
        tv[13].a[15:0] = 16'h0000;
        tv[13].b[63:0] = {16'hFC00, 16'h7E00, 16'hBC00, 16'h7C00};
        tv[13].res[63:0] = {16'h7E00, 16'h7E00, 16'h8000, 16'h7E00};
        tv[14] = '{OP_VDOT, rep(16'h3C00), '0, VW'(16'h4800), 16};
        tv[15] = '{OP_VDOT, rep(16'h3C00), rep(16'h3C00), VW'(16'h7E00), 16};
        tv[15].b[159:144] = 16'h7E00;
        for (int i = 0; i < 16; i++) begin
            tv[11].a[i*16 +: 16]   = add_a[i];
            tv[11].b[i*16 +: 16]   = add_b[i];
            tv[11].res[i*16 +: 16] = add_y[i];
            tv[12].b[i*16 +: 16]   = mul_b[i];
            tv[12].res[i*16 +: 16] = mul_y[i];
            tv[14].b[i*16 +: 16]   = (i % 2 == 0) ? 16'h4000 : 16'hBC00;
        end

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.opcode    = '0;
        bus.op_1      = '0;
        bus.op_2      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_int("reset in_ready", int'(bus.in_ready), 1);
        check_int("reset out_valid", int'(bus.out_valid), 0);
        check_vec("reset result", bus.result, '0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++)
            run_op(tv[i], $sformatf("vec%0d", i), 1'b0);

        run_op(tv[2], "hold_smul", 1'b1);
        run_op(tv[3], "hold_sll", 1'b1);

        // Reset in the 7th cycle of a VDOT, with a competing request on the same edge.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = OP_VDOT;
        bus.op_1     = rep(16'h3C00);
        bus.op_2     = rep(16'h3C00);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_int("vdot mid-run out_valid", int'(bus.out_valid), 0);
        check_int("vdot mid-run in_ready", int'(bus.in_ready), 0);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.opcode   = OP_SLL;
        @(posedge clk);
        @(negedge clk);
        check_int("rst out_valid", int'(bus.out_valid), 0);
        check_int("rst in_ready", int'(bus.in_ready), 1);
        check_vec("rst result", bus.result, '0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        run_op(tv[0], "post_rst_vadd", 1'b0);
        run_op(tv[11], "post_rst_vadd_special", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
